// File: rtl/elpis_print_receiver.sv
// elpis_print_receiver: host-side capture of Elpis print events.
// Rising edges of the print enable push the print value into a show-ahead
// FIFO drained through rd_valid/pop. Drops on a full FIFO set a sticky
// overflow flag and a saturating drop counter; irq is a registered level.
// Optional feature macro: ELPIS_PRINT_TIMESTAMP_EN stores a 32-bit capture
// cycle stamp with every entry (rd_timestamp is tied to 0 otherwise).
module elpis_print_receiver #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 8,
    parameter int IRQ_THRESHOLD = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       output_enabled_from_elpis,
    input  logic [DATA_WIDTH-1:0]      output_data_from_elpis,
    input  logic                       pop,
    input  logic                       clear_overflow,
    output logic                       rd_valid,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [31:0]                rd_timestamp,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    output logic                       irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic                  en_p1;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0]      count_q, count_nxt;
    logic                  ovf_q, ovf_nxt;
    logic [7:0]            drop_q, drop_nxt;
    logic                  irq_q, irq_nxt;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_nxt;
    logic                  push, pop_ok, full, push_ok, drop;
    logic                  head_from_push, head_load;

    // Next-state decode for capture, drain, overflow and head selection
    always_comb begin
        push    = output_enabled_from_elpis && !en_p1;
        pop_ok  = pop && (count_q != '0);
        full    = (count_q == CNT_W'(DEPTH));
        push_ok = push && (!full || pop_ok);
        drop    = push && full && !pop_ok;

        wr_ptr_nxt = push_ok ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_nxt = pop_ok  ? rd_ptr + PTR_W'(1) : rd_ptr;

        count_nxt = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase

        // A drop in the same cycle as a clear wins: counting restarts at 1
        ovf_nxt  = ovf_q;
        drop_nxt = drop_q;
        if (drop) begin
            ovf_nxt  = 1'b1;
            drop_nxt = clear_overflow ? 8'd1 : sat_inc8(drop_q);
        end else if (clear_overflow) begin
            ovf_nxt  = 1'b0;
            drop_nxt = 8'd0;
        end

        irq_nxt = (count_nxt >= CNT_W'(IRQ_THRESHOLD)) || ovf_nxt;

        // New head is the incoming word only when it lands in an otherwise empty FIFO
        head_from_push = push_ok && (count_nxt == CNT_W'(1));
        head_load      = (count_nxt != '0);
        head_data_nxt  = head_from_push ? output_data_from_elpis : mem[rd_ptr_nxt];
    end

    // Control state: pointers, occupancy, flags, enable history, head register
    always_ff @(posedge clk) begin
        if (!reset) begin
            en_p1       <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 8'd0;
            irq_q       <= 1'b0;
            head_data_q <= '0;
        end else begin
            en_p1   <= output_enabled_from_elpis;
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            ovf_q   <= ovf_nxt;
            drop_q  <= drop_nxt;
            irq_q   <= irq_nxt;
            if (head_load) begin
                head_data_q <= head_data_nxt;
            end
        end
    end

    // Entry storage: data path only, no reset
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem[wr_ptr] <= output_data_from_elpis;
        end
    end

`ifdef ELPIS_PRINT_TIMESTAMP_EN
    logic [31:0] ts_ctr;
    logic [31:0] ts_mem [DEPTH];
    logic [31:0] head_ts_q, head_ts_nxt;

    // Head timestamp follows the same selection as head data
    always_comb begin
        head_ts_nxt = head_from_push ? ts_ctr : ts_mem[rd_ptr_nxt];
    end

    // Free-running capture-cycle counter and head timestamp register
    always_ff @(posedge clk) begin
        if (!reset) begin
            ts_ctr    <= 32'd0;
            head_ts_q <= 32'd0;
        end else begin
            ts_ctr <= ts_ctr + 32'd1;
            if (head_load) begin
                head_ts_q <= head_ts_nxt;
            end
        end
    end

    // Timestamp storage alongside each entry
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            ts_mem[wr_ptr] <= ts_ctr;
        end
    end

    assign rd_timestamp = head_ts_q;
`else
    assign rd_timestamp = 32'd0;
`endif

    assign rd_valid   = (count_q != '0);
    assign rd_data    = head_data_q;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_elpis_print_receiver.sv
// Directed, table-driven bench for elpis_print_receiver (DEPTH=8, IRQ_THRESHOLD=3).
module tb_elpis_print_receiver;

    localparam int DW  = 32;
    localparam int DEP = 8;
    localparam int THR = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [DW-1:0] din;
    logic          pop;
    logic          clr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [31:0]   rd_timestamp;
    logic [3:0]    count;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    elpis_print_receiver #(.DATA_WIDTH(DW), .DEPTH(DEP), .IRQ_THRESHOLD(THR)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .output_enabled_from_elpis (en),
        .output_data_from_elpis    (din),
        .pop                       (pop),
        .clear_overflow            (clr),
        .rd_valid                  (rd_valid),
        .rd_data                   (rd_data),
        .rd_timestamp              (rd_timestamp),
        .count                     (count),
        .overflow                  (overflow),
        .drop_count                (drop_count),
        .irq                       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] d;
        logic        pop;
        logic        clr;
        logic        ev;
        logic [31:0] ed;
        int          ecnt;
        logic        eovf;
        int          edrop;
        logic        eirq;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] ed,
                           input int ecnt, input logic eovf, input int edrop, input logic eirq);
        chk({tag, ".rd_valid"},   32'(rd_valid),   32'(ev));
        chk({tag, ".rd_data"},    rd_data,         ed);
        chk({tag, ".count"},      32'(count),      32'(ecnt));
        chk({tag, ".overflow"},   32'(overflow),   32'(eovf));
        chk({tag, ".drop_count"}, 32'(drop_count), 32'(edrop));
        chk({tag, ".irq"},        32'(irq),        32'(eirq));
    endtask

    function automatic logic xirq(input int c, input logic o);
        return (c >= THR) || o;
    endfunction

    task automatic add(input logic e, input logic [31:0] d, input logic p, input logic c,
                       input logic ev, input logic [31:0] ed, input int ecnt,
                       input logic eovf, input int edrop);
        vec_t v;
        v.en = e; v.d = d; v.pop = p; v.clr = c;
        v.ev = ev; v.ed = ed; v.ecnt = ecnt; v.eovf = eovf; v.edrop = edrop;
        v.eirq = xirq(ecnt, eovf);
        tbl.push_back(v);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            en  = tbl[i].en;
            din = tbl[i].d;
            pop = tbl[i].pop;
            clr = tbl[i].clr;
            step();
            chk_all($sformatf("%s[%0d]", tag, i), tbl[i].ev, tbl[i].ed, tbl[i].ecnt,
                    tbl[i].eovf, tbl[i].edrop, tbl[i].eirq);
        end
        tbl.delete();
        en = 1'b0; pop = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        step();
        chk_all(tag, 1'b0, 32'h0, 0, 1'b0, 0, 1'b0);
        chk({tag, ".rd_timestamp"}, rd_timestamp, 32'h0);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] ts1, ts2;
        reset = 1'b0; en = 1'b0; din = '0; pop = 1'b0; clr = 1'b0;

        // Reset held 3 cycles, then released with enable low
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("rst", 1'b0, 32'h0, 0, 1'b0, 0, 1'b0);
        end
        reset = 1'b1;
        step();
        chk_all("rel", 1'b0, 32'h0, 0, 1'b0, 0, 1'b0);

        // Single pulse then 4-cycle hold: two entries, in order
        add(1, 32'h0000_00A5, 0, 0, 1, 32'h0000_00A5, 1, 0, 0);
        add(0, 32'h0,         0, 0, 1, 32'h0000_00A5, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            add(1, 32'h1234_5678, 0, 0, 1, 32'h0000_00A5, 2, 0, 0);
        add(0, 32'h0, 0, 0, 1, 32'h0000_00A5, 2, 0, 0);
        add(0, 32'h0, 1, 0, 1, 32'h1234_5678, 1, 0, 0);
        add(0, 32'h0, 1, 0, 0, 32'h1234_5678, 0, 0, 0);
        run_table("hold");

        // Ten pulses into DEPTH=8: two drops, drain 1..8, clear
        for (int k = 1; k <= 10; k++) begin
            add(1, 32'(k), 0, 0, 1, 32'd1, (k > 8) ? 8 : k, k > 8, (k > 8) ? k - 8 : 0);
            add(0, 32'h0,  0, 0, 1, 32'd1, (k > 8) ? 8 : k, k > 8, (k > 8) ? k - 8 : 0);
        end
        for (int i = 1; i <= 8; i++)
            add(0, 32'h0, 1, 0, i < 8, (i < 8) ? 32'(i + 1) : 32'd8, 8 - i, 1, 2);
        add(0, 32'h0, 0, 1, 0, 32'd8, 0, 0, 0);
        run_table("ovf");

        // Full FIFO: drop, drop+clear, clear, then push+pop on full; empty pop; push+pop on empty
        for (int k = 1; k <= 8; k++) begin
            add(1, 32'(k), 0, 0, 1, 32'd1, k, 0, 0);
            add(0, 32'h0,  0, 0, 1, 32'd1, k, 0, 0);
        end
        add(1, 32'hEE, 0, 0, 1, 32'd1, 8, 1, 1);
        add(0, 32'h0,  0, 0, 1, 32'd1, 8, 1, 1);
        add(1, 32'hEF, 0, 1, 1, 32'd1, 8, 1, 1);
        add(0, 32'h0,  0, 1, 1, 32'd1, 8, 0, 0);
        add(1, 32'd9,  1, 0, 1, 32'd2, 8, 0, 0);
        add(0, 32'h0,  0, 0, 1, 32'd2, 8, 0, 0);
        for (int i = 1; i <= 8; i++)
            add(0, 32'h0, 1, 0, i < 8, (i < 8) ? 32'(i + 2) : 32'd9, 8 - i, 0, 0);
        add(0, 32'h0,  1, 0, 0, 32'd9,  0, 0, 0);
        add(1, 32'h77, 1, 0, 1, 32'h77, 1, 0, 0);
        add(0, 32'h0,  1, 0, 0, 32'h77, 0, 0, 0);
        run_table("full");

        // drop_count saturates at 255
        for (int k = 1; k <= 8; k++) begin
            add(1, 32'(100 + k), 0, 0, 1, 32'd101, k, 0, 0);
            add(0, 32'h0,        0, 0, 1, 32'd101, k, 0, 0);
        end
        for (int j = 1; j <= 260; j++) begin
            add(1, 32'h0, 0, 0, 1, 32'd101, 8, 1, (j > 255) ? 255 : j);
            add(0, 32'h0, 0, 0, 1, 32'd101, 8, 1, (j > 255) ? 255 : j);
        end
        run_table("sat");

        // Mid-run reset discards the full FIFO
        do_reset("midrst0");

        // irq threshold 3: pushes 1..3 then one pop
        add(1, 32'h31, 0, 0, 1, 32'h31, 1, 0, 0);
        add(0, 32'h0,  0, 0, 1, 32'h31, 1, 0, 0);
        add(1, 32'h32, 0, 0, 1, 32'h31, 2, 0, 0);
        add(0, 32'h0,  0, 0, 1, 32'h31, 2, 0, 0);
        add(1, 32'h33, 0, 0, 1, 32'h31, 3, 0, 0);
        add(0, 32'h0,  0, 0, 1, 32'h31, 3, 0, 0);
        add(0, 32'h0,  1, 0, 1, 32'h32, 2, 0, 0);
        run_table("irq");
        chk("irq.after_pop", 32'(irq), 32'd0);
        do_reset("midrst1");

        // Timestamps: pushes on the 5th and 12th edges after release
        for (int i = 0; i < 4; i++) step();
        en = 1'b1; din = 32'h51; step();
        en = 1'b0;
        for (int i = 0; i < 6; i++) step();
        en = 1'b1; din = 32'h52; step();
        en = 1'b0; step();
        chk("ts.count", 32'(count), 32'd2);
        chk("ts.data1", rd_data, 32'h51);
        ts1 = rd_timestamp;
        pop = 1'b1; step(); pop = 1'b0;
        chk("ts.data2", rd_data, 32'h52);
        ts2 = rd_timestamp;
`ifdef ELPIS_PRINT_TIMESTAMP_EN
        chk("ts.first", ts1, 32'd4);
        chk("ts.delta", ts2 - ts1, 32'd7);
`else
        chk("ts.first", ts1, 32'd0);
        chk("ts.second", ts2, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elpis_print_receiver.md
Name: elpis_print_receiver

Overview:
- Host-side (management/Pico) end of the Elpis print path.
- Consumes the print enable/data pair that the output arbiter drives out of the chip top.
- Captures each print event into a show-ahead FIFO that the host drains through a valid/pop handshake.
- Flags overflow and raises a level interrupt once the FIFO reaches a fill threshold.

Parameters:
- DATA_WIDTH, 32, width of a printed value.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- IRQ_THRESHOLD, 1, irq asserts while count >= IRQ_THRESHOLD; range 1..DEPTH.

Ports:
- clk  input  1  single clock domain.
- reset  input  1  synchronous, active-low reset.
- output_enabled_from_elpis  input  1  print enable from the Elpis output arbiter.
- output_data_from_elpis  input  DATA_WIDTH  print value; valid while enable is high.
- pop  input  1  host consumes the head entry.
- clear_overflow  input  1  clears the sticky overflow flag and drop_count.
- rd_valid  output  1  FIFO non-empty.
- rd_data  output  DATA_WIDTH  head entry (show-ahead).
- rd_timestamp  output  32  head entry's capture cycle (see Optional Feature).
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky; set when a print event is dropped.
- drop_count  output  8  dropped events, saturating at 255.
- irq  output  1  level interrupt.

Behaviour:
- Reset (reset==0 at a clk edge): rd/wr pointers 0, count 0, overflow 0, drop_count 0, enable-history register 0, timestamp counter 0.
- While reset is low, the block ignores pop, enable and clear_overflow.
- Outputs during and after reset: rd_valid 0, rd_data 0, rd_timestamp 0, irq 0.
- A mid-operation reset discards every stored entry.

Capture (push):
- One push per rising edge of output_enabled_from_elpis: enable==1 and the history register holds 0.
- The block samples output_data_from_elpis in that same cycle.
- Holding enable high for N cycles produces one entry.
- The history register resets to 0. Enable already high on the first cycle after reset release therefore captures once.

Read:
- rd_valid = (count != 0).
- rd_data and rd_timestamp always show the head entry. When the FIFO is empty they hold the last popped value (undefined after reset = 0).
- pop with rd_valid==1 advances the read pointer at the clock edge.
- pop with rd_valid==0 is ignored: no underflow, no state change.

Latency:
- A push into an empty FIFO gives rd_valid=1 and the new rd_data on the cycle after the capture edge.

Pointers:
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count tracks occupancy; full = (count == DEPTH).

Simultaneous events:
- Push + pop, FIFO non-empty and not full: both happen, count unchanged.
- Push + pop, FIFO full: the pop frees a slot and the push is accepted. count stays DEPTH, no overflow.
- Push + pop, FIFO empty: the pop is ignored, the push happens, count becomes 1.
- Push, FIFO full, no pop: the event is dropped and no FIFO contents change. overflow<=1; drop_count increments and saturates at 255.
- clear_overflow in the same cycle as a drop: the set wins. overflow stays 1 and drop_count becomes 1.

irq:
- Registered, equal to (count >= IRQ_THRESHOLD) || overflow, evaluated on next-state values.
- Deasserts the cycle after the condition clears.

Optional Feature:
- Macro: ELPIS_PRINT_TIMESTAMP_EN.
- Enabled:
  - A free-running 32-bit cycle counter starts at 0 after reset and wraps at 2^32.
  - Each entry stores the counter value from its capture cycle.
  - rd_timestamp shows the head entry's stored value.
- Disabled:
  - No counter and no timestamp storage.
  - rd_timestamp is tied to 0.
  - All other behaviour is identical.

Test Plan:
1. Reset low for 3 cycles, then release; enable stays 0. Required: rd_valid=0, count=0, irq=0, overflow=0, drop_count=0 throughout.
2. Enable pulsed high for 1 cycle with data 0x0000_00A5, then held high for 4 cycles with 0x1234_5678. Required: count=2 and order A5 then 12345678. rd_valid rises exactly 1 cycle after the first edge.
3. DEPTH=8: 10 separate enable pulses with data 1..10, no pop. Required: count=8, overflow=1, drop_count=2. Popping drains 1..8 in order. One clear_overflow pulse then gives overflow=0 and drop_count=0.
4. FIFO full (data 1..8) with push of 9 and pop in the same cycle. Required: overflow stays 0, count stays 8, drain order 2..9. Separately, pop with an empty FIFO: count stays 0, no state change.
5. IRQ_THRESHOLD=3: 3 pushes, then 1 pop. Required: irq=0 after pushes 1 and 2, irq=1 after push 3, irq=0 the cycle after the pop. Reset asserted mid-run: count=0, irq=0, rd_valid=0 on the next cycle.
6. ELPIS_PRINT_TIMESTAMP_EN defined, pushes 5 cycles and 12 cycles after reset release. Required: rd_timestamp of the first entry is 4, and the second entry's timestamp minus the first is 7. With the macro undefined, rd_timestamp stays 0.
